// File: rtl/gate_sweep_checker.sv
`default_nettype none
// gate_sweep_checker: drives a two-input gate bank through all a/b vectors and checks its seven results.
// Define GATE_SWEEP_FIRST_FAIL_EN to add first-failure capture outputs.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       res_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_bits
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0]       PASS_LAST = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       fail_q, fail_d;

  logic [6:0]       expected, mismatch;
  logic [3:0]       mis_cnt;
  logic [ERR_W+3:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  // Expected results come from the registered drive values, which are stable through CHECK.
  always_comb begin
    expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~b_q, ~(a_q & b_q), a_q | b_q, a_q & b_q};
    mismatch = res_in ^ expected;
    mis_cnt  = '0;
    for (int i = 0; i < 7; i++) begin
      mis_cnt = mis_cnt + {3'b000, mismatch[i]};
    end
    err_sum = {4'b0000, err_q} + {{ERR_W{1'b0}}, mis_cnt};
    err_sat = (err_sum > {4'b0000, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = 2'd0;
          pcnt_d  = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      ST_DRIVE: begin
        settle_d = SETTLE_LD;
        state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q <= 4'd1) begin
          settle_d = 4'd0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_CHECK: begin
        fail_d = fail_q | mismatch;
        err_d  = err_sat;
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          state_d = ST_DRIVE;
        end else if (pcnt_q < PASS_LAST) begin
          vec_d   = 2'd0;
          {a_d, b_d} = 2'd0;
          pcnt_d  = pcnt_q + 4'd1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_sat == '0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      pcnt_q   <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = fail_q;

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ffvec_q, ffvec_d;
  logic [6:0] ffbits_q, ffbits_d;

  // Capture once per sweep; frozen until the next accepted start.
  always_comb begin
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    ffbits_d = ffbits_q;
    if (state_q == ST_IDLE && start) begin
      ffv_d    = 1'b0;
      ffvec_d  = '0;
      ffbits_d = '0;
    end else if (state_q == ST_CHECK && !ffv_q && mismatch != '0) begin
      ffv_d    = 1'b1;
      ffvec_d  = vec_q;
      ffbits_d = mismatch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      ffbits_q <= '0;
    end else begin
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      ffbits_q <= ffbits_d;
    end
  end

  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_bits  = ffbits_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// Bench for gate_sweep_checker: faulty/random gate bank models feed two configurations of the checker.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [6:0] res0, res1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err0;
  logic [3:0] err1;
  logic [6:0] fm0, fm1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [1:0] ffvec0, ffvec1;
  logic [6:0] ffb0, ffb1;
`endif

  gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .res_in(res0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(fm0)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .first_fail_bits(ffb0)
`endif
  );

  gate_sweep_checker #(.SETTLE_CYCLES(0), .PASSES(2), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .res_in(res1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(fm1)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_bits(ffb1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] flip_tab [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] truth(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~b, ~(a & b), a | b, a & b};
  endfunction

  // Gate bank under test: 0 good, 1 xor stuck-at-0, 2 all inverted, 3 not=~a, 4 random flip table.
  function automatic logic [6:0] bank(input int mode, input logic [1:0] v);
    logic [6:0] t;
    t = truth(v[1], v[0]);
    case (mode)
      1:       return t & 7'h5F;
      2:       return ~t;
      3:       return {t[6:4], ~v[1], t[2:0]};
      4:       return t ^ flip_tab[v];
      default: return t;
    endcase
  endfunction

  task automatic set_in(input int w, input logic st, input logic [6:0] r);
    if (w == 0) begin start0 = st; res0 = r; end
    else        begin start1 = st; res1 = r; end
  endtask

  task automatic snap(input int w, output logic [1:0] ab, output logic bz, output logic dn,
                      output logic ps, output logic [7:0] er, output logic [6:0] fm);
    if (w == 0) begin ab = {a0, b0}; bz = busy0; dn = done0; ps = pass0; er = err0; fm = fm0; end
    else begin ab = {a1, b1}; bz = busy1; dn = done1; ps = pass1; er = {4'b0, err1}; fm = fm1; end
  endtask

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  task automatic snap_ff(input int w, output logic v, output logic [1:0] vc, output logic [6:0] bt);
    if (w == 0) begin v = ffv0; vc = ffvec0; bt = ffb0; end
    else        begin v = ffv1; vc = ffvec1; bt = ffb1; end
  endtask
`endif

  // One full sweep on DUT w; abort_k >= 0 asserts rst in that cycle instead of finishing.
  task automatic sweep(input int w, input int mode, input int abort_k, input bit rand_start,
                       output logic [7:0] err_o, output logic [6:0] fm_o, output logic pass_o);
    int S, P, W, N, v, tot, first_v;
    logic [6:0] fm_exp, first_bits, m, r;
    logic [1:0] ab, vb;
    logic bz, dn, ps, st;
    logic [7:0] er;
    logic [6:0] fm;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic ffv;
    logic [1:0] ffvec;
    logic [6:0] ffb;
`endif
    S = (w == 0) ? 1 : 0;
    P = (w == 0) ? 1 : 2;
    W = (w == 0) ? 8 : 4;
    N = 4 * P * (S + 2);
    tot = 0; fm_exp = '0; first_v = -1; first_bits = '0;
    for (int p = 0; p < P; p++) begin
      for (int vv = 0; vv < 4; vv++) begin
        vb = 2'(vv);
        m = bank(mode, vb) ^ truth(vb[1], vb[0]);
        tot += $countones(m);
        fm_exp |= m;
        if (first_v < 0 && m != '0) begin first_v = vv; first_bits = m; end
      end
    end
    if (tot > (1 << W) - 1) tot = (1 << W) - 1;
    err_o = '0; fm_o = '0; pass_o = 1'b0;

    @(negedge clk);
    set_in(w, 1'b1, 7'($urandom));
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      v = (k / (S + 2)) % 4;
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        snap(w, ab, bz, dn, ps, er, fm);
        chk("rst_ab", 32'(ab), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_pass", 32'(ps), 32'd0);
        chk("rst_err", 32'(er), 32'd0);
        chk("rst_fm", 32'(fm), 32'd0);
        set_in(w, 1'b0, 7'($urandom));
        repeat (3) begin
          @(negedge clk);
          snap(w, ab, bz, dn, ps, er, fm);
          chk("rst_hold_done", 32'(dn), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        snap(w, ab, bz, dn, ps, er, fm);
        chk("post_rst_done", 32'(dn), 32'd0);
        chk("post_rst_busy", 32'(bz), 32'd0);
        return;
      end
      snap(w, ab, bz, dn, ps, er, fm);
      if (k == 0) begin
        chk("start_clr_err", 32'(er), 32'd0);
        chk("start_clr_fm", 32'(fm), 32'd0);
        chk("start_clr_pass", 32'(ps), 32'd0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        snap_ff(w, ffv, ffvec, ffb);
        chk("start_clr_ffv", 32'(ffv), 32'd0);
`endif
      end
      if (k < N) begin
        chk("busy", 32'(bz), 32'd1);
        chk("done_early", 32'(dn), 32'd0);
        chk("ab_seq", 32'(ab), 32'(v));
      end else begin
        chk(k == N ? "done_pulse" : "done_width", 32'(dn), (k == N) ? 32'd1 : 32'd0);
        chk("busy_end", 32'(bz), 32'd0);
        chk("ab_hold", 32'(ab), 32'd3);
        chk("err", 32'(er), 32'(tot));
        chk("fail_mask", 32'(fm), 32'(fm_exp));
        chk("pass", 32'(ps), (tot == 0) ? 32'd1 : 32'd0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        snap_ff(w, ffv, ffvec, ffb);
        chk("ff_valid", 32'(ffv), (first_v >= 0) ? 32'd1 : 32'd0);
        chk("ff_vec", 32'(ffvec), (first_v >= 0) ? 32'(first_v) : 32'd0);
        chk("ff_bits", 32'(ffb), 32'(first_bits));
`endif
        err_o = er; fm_o = fm; pass_o = ps;
      end
      // Correct-response data only in the CHECK cycle; junk elsewhere must be ignored.
      st = (rand_start && k <= N) ? 1'($urandom_range(0, 1)) : 1'b0;
      vb = 2'(v);
      r  = (k < N && (k % (S + 2)) == S + 1) ? bank(mode, vb) : 7'($urandom);
      set_in(w, st, r);
    end
  endtask

  initial begin
    logic [7:0] er;
    logic [6:0] fm;
    logic ps;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; res0 = '0; res1 = '0;
    for (int i = 0; i < 4; i++) flip_tab[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_err0", 32'(err0), 32'd0);
    chk("reset_ab0", 32'({a0, b0}), 32'd0);
    chk("reset_err1", 32'(err1), 32'd0);
    rst = 1'b0;

    sweep(0, 0, -1, 1'b0, er, fm, ps);
    chk("t1_pass_lit", 32'(ps), 32'd1);
    chk("t1_err_lit", 32'(er), 32'd0);
    sweep(0, 1, -1, 1'b0, er, fm, ps);
    chk("t2_err_lit", 32'(er), 32'd2);
    chk("t2_fm_lit", 32'(fm), 32'h20);
    sweep(1, 2, -1, 1'b0, er, fm, ps);
    chk("t3_err_sat_lit", 32'(er), 32'd15);
    chk("t3_fm_lit", 32'(fm), 32'h7F);
    sweep(0, 2, -1, 1'b1, er, fm, ps);
    chk("t3b_err_lit", 32'(er), 32'd28);
    sweep(0, 3, -1, 1'b0, er, fm, ps);
    chk("t4_err_lit", 32'(er), 32'd2);
    chk("t4_fm_lit", 32'(fm), 32'h08);
    sweep(1, 0, -1, 1'b1, er, fm, ps);
    chk("t5_err_lit", 32'(er), 32'd0);
    sweep(0, 2, 7, 1'b0, er, fm, ps);
    sweep(0, 0, -1, 1'b0, er, fm, ps);
    chk("t6_pass_lit", 32'(ps), 32'd1);

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) flip_tab[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      sweep(it % 2, 4, -1, 1'($urandom_range(0, 1)), er, fm, ps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
